// File: rtl/bcd_down_timer_pkg.sv
// Shared types and constants for the two-digit BCD countdown timer.
// Digit width, BCD limit, FSM state encoding and preset clamping.
package bcd_down_timer_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_timer_digit_dec.sv
// One BCD digit of a borrow-chained decrementer (combinational).
// A borrow out of a zero digit wraps that digit to 9.
module bcd_digit_dec
    import bcd_down_timer_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] digit_next,
    output logic               borrow_out
);

    always_comb begin
        digit_next = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == '0) begin
                digit_next = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                digit_next = digit - DIGIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bcd_down_timer.sv
// Two-digit BCD countdown timer with preset load, start/pause control,
// TICK_DIV prescaler and a one-cycle done pulse when the count reaches 00.
module bcd_down_timer
    import bcd_down_timer_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_0,
    input  logic [DIGIT_W-1:0] load_1,
    input  logic               start,
    input  logic               pause,
    output logic [DIGIT_W-1:0] bcd_0,
    output logic [DIGIT_W-1:0] bcd_1,
    output logic               busy,
    output logic               done
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_e             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [DIGIT_W-1:0] ones_q, ones_d, tens_q, tens_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [DIGIT_W-1:0] ones_dec, tens_dec;
    logic               ones_borrow, underflow;
    logic               count_zero, dec_zero;

    bcd_digit_dec u_dec_ones (
        .digit      (ones_q),
        .borrow_in  (1'b1),
        .digit_next (ones_dec),
        .borrow_out (ones_borrow)
    );

    bcd_digit_dec u_dec_tens (
        .digit      (tens_q),
        .borrow_in  (ones_borrow),
        .digit_next (tens_dec),
        .borrow_out (underflow)
    );

    assign count_zero = (ones_q == '0) && (tens_q == '0);
    assign dec_zero   = (ones_dec == '0) && (tens_dec == '0);

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        done_d  = 1'b0;

        if (load) begin
            state_d = IDLE;
            pre_d   = '0;
            ones_d  = clamp_digit(load_0);
            tens_d  = clamp_digit(load_1);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !count_zero) begin
                        state_d = RUN;
                        pre_d   = '0;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (pre_q == PRE_LAST) begin
                        pre_d = '0;
                        // A borrow out of the tens digit would mean going below 00.
                        if (!underflow) begin
                            ones_d = ones_dec;
                            tens_d = tens_dec;
                            if (dec_zero) begin
                                state_d = EXPIRED;
                                done_d  = 1'b1;
                            end
                        end
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                EXPIRED: begin
                    state_d = EXPIRED;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == RUN) || (state_d == PAUSE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            pre_q   <= '0;
            ones_q  <= '0;
            tens_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bcd_0 = ones_q;
    assign bcd_1 = tens_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Scoreboard bench for bcd_down_timer: dut 0 runs TICK_DIV=1, dut 1 runs TICK_DIV=4.
// Stimulus pushes the expected post-edge outputs; a monitor pops and compares them.
module tb_bcd_down_timer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_0 = 4'd0;
    logic [3:0] load_1 = 4'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;

    logic [3:0] a_b0, a_b1, b_b0, b_b1;
    logic       a_busy, a_done, b_busy, b_done;

    int n_chk = 0;
    int n_fail = 0;
    int edge_cnt = 0;

    typedef struct {
        int         edge_no;
        int         dut;
        logic [9:0] val;
        string      nm;
    } exp_t;

    exp_t sb[$];

    bcd_down_timer #(.TICK_DIV(1)) u_a (
        .CLK(CLK), .RST(RST), .load(load), .load_0(load_0), .load_1(load_1),
        .start(start), .pause(pause), .bcd_0(a_b0), .bcd_1(a_b1),
        .busy(a_busy), .done(a_done)
    );

    bcd_down_timer #(.TICK_DIV(4)) u_b (
        .CLK(CLK), .RST(RST), .load(load), .load_0(load_0), .load_1(load_1),
        .start(start), .pause(pause), .bcd_0(b_b0), .bcd_1(b_b1),
        .busy(b_busy), .done(b_done)
    );

    always #5 CLK = ~CLK;

    function automatic logic [9:0] dut_out(int d);
        return (d == 0) ? {a_b1, a_b0, a_busy, a_done} : {b_b1, b_b0, b_busy, b_done};
    endfunction

    function automatic void chk(string nm, int d, logic [9:0] act, logic [9:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s dut%0d: got bcd=%h%h busy=%b done=%b, expected bcd=%h%h busy=%b done=%b",
                     nm, d, act[9:6], act[5:2], act[1], act[0],
                     expv[9:6], expv[5:2], expv[1], expv[0]);
        end
    endfunction

    // Expected outputs after the next rising edge; v is the decimal count.
    function automatic void expx(int d, int v, logic bz, logic dn, string nm);
        exp_t e;
        e.edge_no = edge_cnt + 1;
        e.dut     = d;
        e.val     = {4'(v / 10), 4'(v % 10), bz, dn};
        e.nm      = nm;
        sb.push_back(e);
    endfunction

    task automatic drv(input logic ld, input logic [3:0] l1, input logic [3:0] l0,
                       input logic st, input logic ps);
        @(negedge CLK);
        load   = ld;
        load_1 = l1;
        load_0 = l0;
        start  = st;
        pause  = ps;
    endtask

    task automatic idle();
        drv(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic ld(input logic [3:0] l1, input logic [3:0] l0);
        drv(1'b1, l1, l0, 1'b0, 1'b0);
    endtask

    task automatic go();
        drv(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            edge_cnt++;
            #1;
            while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
                e = sb.pop_front();
                if (e.edge_no < edge_cnt) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL %s dut%0d: expectation for edge %0d not checked by edge %0d",
                             e.nm, e.dut, e.edge_no, edge_cnt);
                end else begin
                    chk(e.nm, e.dut, dut_out(e.dut), e.val);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // Reset held with clock running.
        #52;
        chk("reset_hold", 0, dut_out(0), 10'd0);
        chk("reset_hold", 1, dut_out(1), 10'd0);
        @(negedge CLK);
        RST = 1'b0;
        expx(0, 0, 1'b0, 1'b0, "reset_release");

        // TICK_DIV=1: 59 down to 00.
        ld(4'd5, 4'd9);
        expx(0, 59, 1'b0, 1'b0, "a_load59");
        go();
        expx(0, 59, 1'b1, 1'b0, "a_start59");
        for (int i = 1; i <= 59; i++) begin
            idle();
            expx(0, 59 - i, (i < 59), (i == 59), "a_run59");
        end
        idle();
        expx(0, 0, 1'b0, 1'b0, "a_expired_hold");
        go();
        expx(0, 0, 1'b0, 1'b0, "a_expired_start");
        drv(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        expx(0, 0, 1'b0, 1'b0, "a_expired_pause");

        // TICK_DIV=4: 12 with a pause mid-tick.
        ld(4'd1, 4'd2);
        expx(1, 12, 1'b0, 1'b0, "b_load12");
        go();
        expx(1, 12, 1'b1, 1'b0, "b_start12");
        for (int j = 1; j <= 6; j++) begin
            idle();
            expx(1, (j >= 4) ? 11 : 12, 1'b1, 1'b0, "b_run_pre_pause");
        end
        drv(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        expx(1, 11, 1'b1, 1'b0, "b_pause_enter");
        for (int k = 0; k < 10; k++) begin
            drv(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
            expx(1, 11, 1'b1, 1'b0, "b_pause_hold");
        end
        drv(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        expx(1, 11, 1'b1, 1'b0, "b_resume");
        for (int j = 1; j <= 42; j++) begin
            idle();
            expx(1, 11 - (j + 2) / 4, (j < 42), (j == 42), "b_run_post_pause");
        end
        idle();
        expx(1, 0, 1'b0, 1'b0, "b_expired_hold");

        // Clamp and load priority.
        ld(4'hC, 4'd3);
        expx(0, 93, 1'b0, 1'b0, "a_clamp_tens");
        ld(4'hF, 4'hA);
        expx(0, 99, 1'b0, 1'b0, "a_clamp_both");
        drv(1'b1, 4'd9, 4'd9, 1'b1, 1'b0);
        expx(0, 99, 1'b0, 1'b0, "a_load_beats_start");
        idle();
        expx(0, 99, 1'b0, 1'b0, "a_idle_after_load");

        // Zero preset and short countdown.
        ld(4'd0, 4'd0);
        expx(0, 0, 1'b0, 1'b0, "a_load00");
        go();
        expx(0, 0, 1'b0, 1'b0, "a_start_at_zero");
        idle();
        expx(0, 0, 1'b0, 1'b0, "a_zero_idle");
        ld(4'd0, 4'd3);
        expx(0, 3, 1'b0, 1'b0, "a_load03");
        go();
        expx(0, 3, 1'b1, 1'b0, "a_start03");
        for (int i = 1; i <= 3; i++) begin
            idle();
            expx(0, 3 - i, (i < 3), (i == 3), "a_run03");
        end
        idle();
        expx(0, 0, 1'b0, 1'b0, "a_single_done");
        go();
        expx(0, 0, 1'b0, 1'b0, "a_expired_start2");

        // Load while running at 37.
        ld(4'd4, 4'd0);
        expx(0, 40, 1'b0, 1'b0, "a_load40");
        go();
        expx(0, 40, 1'b1, 1'b0, "a_start40");
        for (int i = 1; i <= 3; i++) begin
            idle();
            expx(0, 40 - i, 1'b1, 1'b0, "a_run40");
        end
        ld(4'd2, 4'd5);
        expx(0, 25, 1'b0, 1'b0, "a_load_midrun");
        idle();
        expx(0, 25, 1'b0, 1'b0, "a_idle_after_midrun");
        go();
        expx(0, 25, 1'b1, 1'b0, "a_restart25");
        idle();
        expx(0, 24, 1'b1, 1'b0, "a_first_dec25");

        // Same on the divided timer, reloading with a partial tick pending.
        ld(4'd3, 4'd8);
        expx(1, 38, 1'b0, 1'b0, "b_load38");
        go();
        expx(1, 38, 1'b1, 1'b0, "b_start38");
        for (int j = 1; j <= 5; j++) begin
            idle();
            expx(1, (j >= 4) ? 37 : 38, 1'b1, 1'b0, "b_run38");
        end
        ld(4'd3, 4'd7);
        expx(1, 37, 1'b0, 1'b0, "b_load_midrun");
        go();
        expx(1, 37, 1'b1, 1'b0, "b_restart37");
        for (int j = 1; j <= 4; j++) begin
            idle();
            expx(1, (j == 4) ? 36 : 37, 1'b1, 1'b0, "b_run37");
        end

        // Asynchronous reset while running.
        ld(4'd5, 4'd0);
        expx(0, 50, 1'b0, 1'b0, "a_load50");
        go();
        expx(0, 50, 1'b1, 1'b0, "a_start50");
        idle();
        expx(0, 49, 1'b1, 1'b0, "a_run50");
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        chk("async_reset", 0, dut_out(0), 10'd0);
        chk("async_reset", 1, dut_out(1), 10'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        expx(0, 0, 1'b0, 1'b0, "a_post_reset");
        expx(1, 0, 1'b0, 1'b0, "b_post_reset");

        idle();
        repeat (3) @(posedge CLK);
        #2;
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
